// File: rtl/tx_frame_byte_serializer.sv
// -----------------------------------------------------------------------------
// tx_frame_byte_serializer
//
// Purpose:
//   TX width converter / framer between the Data Link Layer MAC frame interface
//   and the multi-lane controller. Accepts MAC_FRAME_WIDTH-bit words with
//   valid/ready/last and emits them one byte per handshake, least significant
//   byte first. With ENABLE_FRAMING=1 each packet is bracketed by an STP
//   K-symbol before its first byte and an END K-symbol after its last byte;
//   K-symbols are flagged on is_k_symbol_o. With ENABLE_FRAMING=0 the block is
//   a plain width converter and never emits K-symbols.
//
// Ports:
//   clk_i                   in   1                 clock, all logic on posedge
//   rst_i                   in   1                 synchronous active-high reset
//   mac_data_frame_i        in   MAC_FRAME_WIDTH   DLL word, byte k = [8k+7:8k]
//   mac_data_frame_valid_i  in   1                 word valid
//   mac_data_frame_last_i   in   1                 word is last of packet
//   mac_data_frame_ready_o  out  1                 block accepts a word
//   data_frame_o            out  8                 byte / K-symbol out
//   data_frame_valid_o      out  1                 data_frame_o valid
//   data_frame_ready_i      in   1                 lane controller accepts byte
//   is_k_symbol_o           out  1                 data_frame_o is STP/END
// -----------------------------------------------------------------------------
module tx_frame_byte_serializer #(
  parameter int         MAC_FRAME_WIDTH = 32,
  parameter logic [7:0] STP_SYMBOL      = 8'hFB,
  parameter logic [7:0] END_SYMBOL      = 8'hFD,
  parameter bit         ENABLE_FRAMING  = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [MAC_FRAME_WIDTH-1:0] mac_data_frame_i,
  input  logic                       mac_data_frame_valid_i,
  input  logic                       mac_data_frame_last_i,
  output logic                       mac_data_frame_ready_o,
  output logic [7:0]                 data_frame_o,
  output logic                       data_frame_valid_o,
  input  logic                       data_frame_ready_i,
  output logic                       is_k_symbol_o
);

  localparam int BYTES = MAC_FRAME_WIDTH / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES - 1);

  if (((MAC_FRAME_WIDTH % 8) != 0) || (MAC_FRAME_WIDTH < 8)) begin : g_width_check
    $error("MAC_FRAME_WIDTH must be a multiple of 8 and at least 8");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,  // no packet open, word register empty
    S_STP  = 3'd1,
    S_DATA = 3'd2,
    S_GAP  = 3'd3,  // packet open, waiting for its next word
    S_END  = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [MAC_FRAME_WIDTH-1:0] word_q, word_d;
  logic                       last_q, last_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [7:0]                 data_q, data_d;
  logic                       valid_q, valid_d;
  logic                       k_q, k_d;

  logic last_byte;
  logic ready;
  logic in_hs;
  logic out_hs;

  function automatic logic [7:0] byte_sel(input logic [MAC_FRAME_WIDTH-1:0] w,
                                          input logic [IDX_W-1:0]           idx);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < BYTES; k++) begin
      if (idx == IDX_W'(k)) r = w[8*k +: 8];
    end
    return r;
  endfunction

  always_comb begin
    last_byte = (idx_q == IDX_LAST);
    // The only combinational ready_i -> ready_o path: the final byte of a
    // non-last word leaving lets the next word slide in without a bubble.
    ready  = !rst_i && ((state_q == S_IDLE) || (state_q == S_GAP) ||
                        ((state_q == S_DATA) && last_byte && !last_q && data_frame_ready_i));
    in_hs  = mac_data_frame_valid_i && ready;
    out_hs = valid_q && data_frame_ready_i;
  end

  assign mac_data_frame_ready_o = ready;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    last_d  = last_q;
    idx_d   = idx_q;

    case (state_q)
      S_IDLE: begin
        if (in_hs) begin
          word_d = mac_data_frame_i;
          last_d = mac_data_frame_last_i;
          idx_d  = '0;
          if (ENABLE_FRAMING) state_d = S_STP;
          else                state_d = S_DATA;
        end
      end
      S_STP: begin
        if (out_hs) state_d = S_DATA;
      end
      S_DATA: begin
        if (out_hs) begin
          if (!last_byte) begin
            idx_d = idx_q + IDX_W'(1);
          end else if (last_q) begin
            if (ENABLE_FRAMING) state_d = S_END;
            else                state_d = S_IDLE;
          end else if (in_hs) begin
            word_d = mac_data_frame_i;
            last_d = mac_data_frame_last_i;
            idx_d  = '0;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (in_hs) begin
          word_d  = mac_data_frame_i;
          last_d  = mac_data_frame_last_i;
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_END: begin
        if (out_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state, so they stay put whenever
    // the state does (i.e. while the lane controller stalls).
    data_d  = 8'h00;
    valid_d = 1'b0;
    k_d     = 1'b0;
    case (state_d)
      S_STP: begin
        data_d  = STP_SYMBOL;
        valid_d = 1'b1;
        k_d     = 1'b1;
      end
      S_DATA: begin
        data_d  = byte_sel(word_d, idx_d);
        valid_d = 1'b1;
      end
      S_END: begin
        data_d  = END_SYMBOL;
        valid_d = 1'b1;
        k_d     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      k_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      k_q     <= k_d;
    end
  end

  assign data_frame_o       = data_q;
  assign data_frame_valid_o = valid_q;
  assign is_k_symbol_o      = k_q;

endmodule

// File: tb/tb_tx_frame_byte_serializer.sv
// -----------------------------------------------------------------------------
// tb_tx_frame_byte_serializer
//
// Two instances share clock, reset and byte-side ready: u_dut_a frames packets,
// u_dut_b is the pure width converter. The reference model turns each packet
// into the byte stream the lane controller must see ({k, byte} entries in a
// queue); a monitor pops that queue on every output handshake.
// -----------------------------------------------------------------------------
module tb_tx_frame_byte_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] d_a, d_b;
  logic        v_a, v_b, l_a, l_b;
  logic        rdy_a, rdy_b;
  logic [7:0]  q_a, q_b;
  logic        qv_a, qv_b, k_a, k_b;
  logic        dr = 1'b1;

  always #5 clk = ~clk;

  tx_frame_byte_serializer u_dut_a (
    .clk_i(clk), .rst_i(rst),
    .mac_data_frame_i(d_a), .mac_data_frame_valid_i(v_a), .mac_data_frame_last_i(l_a),
    .mac_data_frame_ready_o(rdy_a),
    .data_frame_o(q_a), .data_frame_valid_o(qv_a), .data_frame_ready_i(dr),
    .is_k_symbol_o(k_a)
  );

  tx_frame_byte_serializer #(.ENABLE_FRAMING(1'b0)) u_dut_b (
    .clk_i(clk), .rst_i(rst),
    .mac_data_frame_i(d_b), .mac_data_frame_valid_i(v_b), .mac_data_frame_last_i(l_b),
    .mac_data_frame_ready_o(rdy_b),
    .data_frame_o(q_b), .data_frame_valid_o(qv_b), .data_frame_ready_i(dr),
    .is_k_symbol_o(k_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [8:0] exp_a[$];
  logic [8:0] exp_b[$];

  bit bp_en   = 1'b0;
  bit rdy_chk = 1'b0;
  int first_a = -1;
  int last_a  = -1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-side ready: all ones, or a 50% random pattern under backpressure.
  always begin
    @(posedge clk);
    #1;
    dr = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitors (sampled on the falling edge, inputs change just after rising).
  bit         pv_a = 0, pr_a = 0, pk_a = 0;
  logic [7:0] pd_a = 0;
  bit         pv_b = 0, pr_b = 0, pk_b = 0;
  logic [7:0] pd_b = 0;

  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      pv_a = 0;
    end else begin
      if (pv_a && !pr_a) begin
        check_eq("hold_valid_a", qv_a, 1);
        check_eq("hold_data_a", {k_a, q_a}, {pk_a, pd_a});
      end
      if (qv_a && dr) begin
        check_eq("expected_avail_a", exp_a.size() != 0, 1);
        if (exp_a.size() != 0) begin
          e = exp_a.pop_front();
          check_eq("byte_a", {k_a, q_a}, e);
          if (first_a < 0) first_a = cyc;
          last_a = cyc;
        end
      end
      if (rdy_chk && qv_a)
        check_eq("ready_o_a", rdy_a, qv_a && !k_a && (q_a == 8'hDD) && dr);
      pv_a = qv_a; pr_a = dr; pd_a = q_a; pk_a = k_a;
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      pv_b = 0;
    end else begin
      if (pv_b && !pr_b) begin
        check_eq("hold_valid_b", qv_b, 1);
        check_eq("hold_data_b", {k_b, q_b}, {pk_b, pd_b});
      end
      if (qv_b && dr) begin
        check_eq("expected_avail_b", exp_b.size() != 0, 1);
        if (exp_b.size() != 0) begin
          e = exp_b.pop_front();
          check_eq("byte_b", {k_b, q_b}, e);
        end
      end
      pv_b = qv_b; pr_b = dr; pd_b = q_b; pk_b = k_b;
    end
  end

  // Offer one word and hold it until accepted (bounded).
  task automatic send_word(input bit b, input logic [31:0] w, input logic lst);
    bit done = 0;
    bit hs;
    if (!b) begin d_a = w; l_a = lst; v_a = 1'b1; end
    else    begin d_b = w; l_b = lst; v_b = 1'b1; end
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      hs = b ? rdy_b : rdy_a;
      @(posedge clk);
      #1;
      if (hs) done = 1;
    end
    if (!b) v_a = 1'b0; else v_b = 1'b0;
    check_eq("word_accepted", done, 1);
  endtask

  // Reference model: a packet becomes [STP] + bytes LSB-first + [END].
  task automatic send_packet(input bit b, input logic [31:0] ws[$]);
    logic [31:0] w;
    if (!b) exp_a.push_back({1'b1, 8'hFB});
    for (int i = 0; i < ws.size(); i++) begin
      w = ws[i];
      for (int k = 0; k < 4; k++) begin
        if (!b) exp_a.push_back({1'b0, w[8*k +: 8]});
        else    exp_b.push_back({1'b0, w[8*k +: 8]});
      end
    end
    if (!b) exp_a.push_back({1'b1, 8'hFD});
    for (int i = 0; i < ws.size(); i++) send_word(b, ws[i], i == ws.size() - 1);
  endtask

  task automatic wait_drain(input bit b);
    int sz;
    sz = b ? exp_b.size() : exp_a.size();
    for (int i = 0; i < 500 && sz != 0; i++) begin
      @(posedge clk);
      #1;
      sz = b ? exp_b.size() : exp_a.size();
    end
    check_eq(b ? "drain_b" : "drain_a", sz, 0);
  endtask

  initial begin
    logic [31:0] ws[$];
    bit          b;
    int          nw;

    // Reset held two cycles with valid asserted
    rst = 1'b1;
    v_a = 1'b1; v_b = 1'b1; l_a = 1'b1; l_b = 1'b1;
    d_a = $urandom; d_b = $urandom;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("rst_ready_a", rdy_a, 0);
      check_eq("rst_valid_a", qv_a, 0);
      check_eq("rst_data_a", q_a, 8'h00);
      check_eq("rst_k_a", k_a, 0);
      check_eq("rst_ready_b", rdy_b, 0);
      check_eq("rst_valid_b", qv_b, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; v_a = 1'b0; v_b = 1'b0;
    @(negedge clk);
    check_eq("idle_ready_a", rdy_a, 1);
    check_eq("idle_valid_a", qv_a, 0);
    @(posedge clk);
    #1;

    // Single-word packet, no backpressure
    first_a = -1;
    ws = {32'h44332211};
    send_packet(0, ws);
    wait_drain(0);
    check_eq("span_single", last_a - first_a + 1, 6);

    // Two-word packet, back-to-back, ready_o only on the DD byte
    first_a = -1;
    rdy_chk = 1'b1;
    ws = {32'hDDCCBBAA, 32'h00FFEE99};
    send_packet(0, ws);
    wait_drain(0);
    rdy_chk = 1'b0;
    check_eq("span_double", last_a - first_a + 1, 10);

    // Same packet under random backpressure
    bp_en = 1'b1;
    send_packet(0, ws);
    wait_drain(0);
    bp_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a packet, right after byte BB
    exp_a.push_back({1'b1, 8'hFB});
    exp_a.push_back({1'b0, 8'hAA});
    exp_a.push_back({1'b0, 8'hBB});
    send_word(0, 32'hDDCCBBAA, 1'b0);
    wait_drain(0);
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_valid_a", qv_a, 0);
    check_eq("post_rst_ready_a", rdy_a, 1);
    @(posedge clk);
    #1;
    first_a = -1;
    ws = {32'h04030201};
    send_packet(0, ws);
    wait_drain(0);
    check_eq("span_after_rst", last_a - first_a + 1, 6);

    // Width conversion only
    ws = {32'h44332211};
    send_packet(1, ws);
    wait_drain(1);
    @(negedge clk);
    check_eq("nf_ready_back_b", rdy_b, 1);
    check_eq("nf_valid_idle_b", qv_b, 0);
    @(posedge clk);
    #1;

    // Random packets on either instance
    for (int p = 0; p < 24; p++) begin
      b     = 1'($urandom_range(0, 1));
      bp_en = 1'($urandom_range(0, 1));
      nw    = $urandom_range(1, 3);
      ws.delete();
      for (int i = 0; i < nw; i++) ws.push_back($urandom);
      send_packet(b, ws);
      wait_drain(b);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    bp_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("final_idle_a", qv_a, 0);
    check_eq("final_idle_b", qv_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
